n64_sdram_arbiter: RTL and testbench
====================================

N64_SDRAM_ARBITER -- requirements
Module: n64_sdram_arbiter

Interface
REQ-001 Parameter N64_BURST_MAX, default 8: consecutive N64 grants allowed while CPU waits.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: cycles without mem_ack before a transaction is aborted.
REQ-003 The clock is sys.clk, input, 1 bit; all state updates on its rising edge.
REQ-004 The reset is sys.reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 Port n64_request, input, 1: N64 PI transaction request, held until n64_ack.
REQ-006 Port n64_write, n64_address, n64_wdata, input, 1/32/16: N64 transaction attributes, stable while n64_request is high.
REQ-007 Port n64_ack, output, 1: N64 transaction done, single-cycle pulse.
REQ-008 Port n64_rdata, output, 16: N64 read data, valid only while n64_ack is high.
REQ-009 Port cpu_request, cpu_write, cpu_address, cpu_wdata, input, 1/1/32/16: CPU/DMA side, same rules as the N64 inputs.
REQ-010 Port cpu_ack, cpu_rdata, output, 1/16: CPU/DMA side, same rules as the N64 outputs.
REQ-011 Port mem_request, mem_write, mem_address, mem_wdata, output, 1/1/32/16: SDRAM controller request, with registered attributes.
REQ-012 Port mem_ack, mem_rdata, input, 1/16: SDRAM controller completion and read data.
REQ-013 Port timeout_error, output, 1: sticky flag, set on any abort.
REQ-014 Port timeout_clear, input, 1: clears timeout_error.

Function
REQ-015 States: IDLE, GRANT_N64, GRANT_CPU; the state register is the only grant record.
REQ-016 IDLE with n64_request only -> GRANT_N64; with cpu_request only -> GRANT_CPU; with neither -> IDLE.
REQ-017 IDLE with both requests -> GRANT_N64, unless burst_count == N64_BURST_MAX, then GRANT_CPU.
REQ-018 burst_count increments, saturating at N64_BURST_MAX, on each N64 grant while cpu_request is high.
REQ-019 burst_count clears on any CPU grant and on any N64 grant made with cpu_request low.
REQ-020 On the IDLE->GRANT transition edge, mem_request is set to 1 and mem_write/address/wdata are loaded from the winner; this gives one cycle of latency from request to mem_request.
REQ-021 mem_request, once set, stays high until the mem_ack cycle or an abort.
REQ-022 n64_ack = mem_ack AND state==GRANT_N64, combinational, with n64_rdata = mem_rdata; the CPU port works the same way with GRANT_CPU.
REQ-023 On the mem_ack cycle, the next state is IDLE and mem_request goes to 0; a requester that deasserts on that same edge is never re-granted.
REQ-024 A requester holding its request after ack is a new transaction and is arbitrated again from IDLE, with no idle gap beyond one cycle.
REQ-025 mem_ack while in IDLE is ignored; no requester ack is produced.
REQ-026 The wait counter clears on each grant and increments each GRANT cycle without mem_ack.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES, the block pulses the granted requester's ack with rdata 16'hFFFF, deasserts mem_request, enters IDLE and sets timeout_error.
REQ-028 If mem_ack and the timeout occur in the same cycle, mem_ack wins: real rdata is returned and no error is flagged.
REQ-029 If timeout_clear and a new timeout occur in the same cycle, set wins.
REQ-030 mem_address and mem_wdata pass through unmodified; the block does no address arithmetic.

Reset
REQ-031 Reset gives: state=IDLE, mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, burst_count=0, wait counter=0, timeout_error=0; the acks are 0 through the state.
REQ-032 Reset mid-transaction drops mem_request on the next edge and produces no ack; a late mem_ack after reset is ignored per REQ-025.

Verification
REQ-033 Single N64 read to 0x1000_0000, mem_ack after 3 cycles with rdata 0xBEEF -> mem_request 1 cycle after request, n64_ack for exactly one cycle with n64_rdata 0xBEEF, cpu_ack never asserted.
REQ-034 Both ports requesting continuously, immediate mem_ack -> grant sequence 8×N64, 1×CPU, 8×N64, 1×CPU; mem_address always matches the granted port.
REQ-035 CPU write 0x1234 to 0x0000_0100 with N64 idle -> mem_write=1, mem_wdata=0x1234, cpu_ack one pulse, burst_count=0.
REQ-036 N64 read with mem_ack withheld -> after 255 cycles n64_ack with rdata 0xFFFF and timeout_error=1; timeout_clear -> timeout_error=0.
REQ-037 Reset asserted 2 cycles into a CPU transaction, mem_ack asserted 1 cycle later -> mem_request=0, no cpu_ack, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/n64_sdram_arbiter_if.sv
// n64_sdram_arbiter_if
// Groups every signal of the SDRAM arbiter except clock and reset.
//   N64 PI port : n64_request/n64_write/n64_address/n64_wdata in, n64_ack/n64_rdata out
//   CPU/DMA port: cpu_request/cpu_write/cpu_address/cpu_wdata in, cpu_ack/cpu_rdata out
//   SDRAM side  : mem_request/mem_write/mem_address/mem_wdata out, mem_ack/mem_rdata in
//   Status      : timeout_error out (sticky), timeout_clear in
// Modport slave is the arbiter's view; modport master is the view of whatever
// drives the requesters and the SDRAM controller around it.
interface n64_sdram_arbiter_if;
  logic        n64_request;
  logic        n64_write;
  logic [31:0] n64_address;
  logic [15:0] n64_wdata;
  logic        n64_ack;
  logic [15:0] n64_rdata;

  logic        cpu_request;
  logic        cpu_write;
  logic [31:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic        timeout_error;
  logic        timeout_clear;

  modport slave (
    input  n64_request, n64_write, n64_address, n64_wdata,
    output n64_ack, n64_rdata,
    input  cpu_request, cpu_write, cpu_address, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_request, mem_write, mem_address, mem_wdata,
    input  mem_ack, mem_rdata,
    output timeout_error,
    input  timeout_clear
  );

  modport master (
    output n64_request, n64_write, n64_address, n64_wdata,
    input  n64_ack, n64_rdata,
    output cpu_request, cpu_write, cpu_address, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_request, mem_write, mem_address, mem_wdata,
    output mem_ack, mem_rdata,
    input  timeout_error,
    output timeout_clear
  );
endinterface

// File: rtl/n64_sdram_arbiter.sv
// n64_sdram_arbiter
// Shares one SDRAM controller port between the N64 PI bus and a CPU/DMA
// requester. N64 has priority, but after N64_BURST_MAX consecutive N64 grants
// made while the CPU was waiting, the CPU gets the next slot. A transaction
// that sees no mem_ack for TIMEOUT_CYCLES grant cycles is aborted: the owner is
// acked with read data 16'hFFFF and the sticky timeout_error flag is set.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - n64_sdram_arbiter_if.slave (requester ports, SDRAM port, status)
module n64_sdram_arbiter #(
  parameter int unsigned N64_BURST_MAX  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  n64_sdram_arbiter_if.slave  bus
);

  localparam int unsigned BURST_W = $clog2(N64_BURST_MAX + 1);
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(N64_BURST_MAX);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_N64,
    GRANT_CPU
  } state_t;

  state_t               state, state_next;
  logic [BURST_W-1:0]   burst_count, burst_next;
  logic [WAIT_W-1:0]    wait_count, wait_next;
  logic                 mem_request_r, mem_request_next;
  logic                 mem_write_r, mem_write_next;
  logic [31:0]          mem_address_r, mem_address_next;
  logic [15:0]          mem_wdata_r, mem_wdata_next;
  logic                 timeout_error_r, timeout_error_next;

  logic                 granted;
  logic                 timeout_hit;
  logic                 txn_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      burst_count     <= '0;
      wait_count      <= '0;
      mem_request_r   <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= '0;
      mem_wdata_r     <= '0;
      timeout_error_r <= 1'b0;
    end else begin
      state           <= state_next;
      burst_count     <= burst_next;
      wait_count      <= wait_next;
      mem_request_r   <= mem_request_next;
      mem_write_r     <= mem_write_next;
      mem_address_r   <= mem_address_next;
      mem_wdata_r     <= mem_wdata_next;
      timeout_error_r <= timeout_error_next;
    end
  end

  always_comb begin
    state_next         = state;
    burst_next         = burst_count;
    wait_next          = wait_count;
    mem_request_next   = mem_request_r;
    mem_write_next     = mem_write_r;
    mem_address_next   = mem_address_r;
    mem_wdata_next     = mem_wdata_r;
    timeout_error_next = timeout_error_r;

    granted     = (state != IDLE);
    // A real mem_ack in the limit cycle beats the abort.
    timeout_hit = granted && !bus.mem_ack && (wait_count == WAIT_LIMIT);
    // Acks are suppressed while reset is asserted so a transaction cut short
    // by reset never completes towards its requester.
    txn_done    = granted && !reset && (bus.mem_ack || timeout_hit);

    case (state)
      IDLE: begin
        if (bus.n64_request && !(bus.cpu_request && burst_count == BURST_LIMIT)) begin
          state_next       = GRANT_N64;
          mem_request_next = 1'b1;
          mem_write_next   = bus.n64_write;
          mem_address_next = bus.n64_address;
          mem_wdata_next   = bus.n64_wdata;
          wait_next        = '0;
          // Only N64 grants that made the CPU wait count towards the burst.
          if (!bus.cpu_request)
            burst_next = '0;
          else if (burst_count != BURST_LIMIT)
            burst_next = burst_count + 1'b1;
        end else if (bus.cpu_request) begin
          state_next       = GRANT_CPU;
          mem_request_next = 1'b1;
          mem_write_next   = bus.cpu_write;
          mem_address_next = bus.cpu_address;
          mem_wdata_next   = bus.cpu_wdata;
          wait_next        = '0;
          burst_next       = '0;
        end
      end
      GRANT_N64, GRANT_CPU: begin
        if (bus.mem_ack || timeout_hit) begin
          state_next       = IDLE;
          mem_request_next = 1'b0;
        end else begin
          wait_next = wait_count + 1'b1;
        end
      end
      default: begin
        state_next       = IDLE;
        mem_request_next = 1'b0;
      end
    endcase

    if (timeout_hit)
      timeout_error_next = 1'b1;
    else if (bus.timeout_clear)
      timeout_error_next = 1'b0;
  end

  assign bus.n64_ack       = txn_done && (state == GRANT_N64);
  assign bus.cpu_ack       = txn_done && (state == GRANT_CPU);
  assign bus.n64_rdata     = bus.mem_ack ? bus.mem_rdata : '1;
  assign bus.cpu_rdata     = bus.mem_ack ? bus.mem_rdata : '1;

  assign bus.mem_request   = mem_request_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_address   = mem_address_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.timeout_error = timeout_error_r;

endmodule

// File: tb/tb_n64_sdram_arbiter.sv
// tb_n64_sdram_arbiter
// Directed scenarios followed by randomized traffic; every cycle the DUT is
// compared against a transaction-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_n64_sdram_arbiter;

  localparam int unsigned BURST_MAX = 8;
  localparam int unsigned TIMEOUT   = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  n64_sdram_arbiter_if bus();

  n64_sdram_arbiter #(
    .N64_BURST_MAX (BURST_MAX),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // stimulus values applied at the next negedge
  bit          in_reset;
  bit          n64_req, n64_wr, cpu_req, cpu_wr, tclr, mem_ack_v;
  logic [31:0] n64_addr, cpu_addr;
  logic [15:0] n64_wd, cpu_wd, mem_rd;
  int          resp_mode;  // 0 manual, 1 random latency, 2 immediate ack
  int          lat;

  // reference model: who owns the memory port and the related counters
  int          owner;      // 0 nobody, 1 N64, 2 CPU
  int          burst, waitc;
  bit          err, m_req, m_wr;
  logic [31:0] m_addr;
  logic [15:0] m_wdata;

  bit          saw_n64_ack, saw_cpu_ack;
  int          n64_ack_cnt, cpu_ack_cnt;
  int          n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cycle();
    bit          done, timed_out;
    logic [15:0] exp_rd;
    int          r;
    @(negedge clk);
    case (resp_mode)
      1: begin
        if (bus.mem_request) begin
          if (lat < 0) begin
            r   = int'($urandom_range(0, 99));
            lat = (r == 0) ? 300 : (r == 1) ? 255 : int'($urandom_range(0, 4));
          end
          if (lat == 0) begin
            mem_ack_v = 1'b1;
            lat       = -1;
          end else begin
            mem_ack_v = 1'b0;
            lat--;
          end
        end else begin
          lat       = -1;
          mem_ack_v = ($urandom_range(0, 7) == 0);
        end
        mem_rd = 16'($urandom);
      end
      2: mem_ack_v = bus.mem_request;
      default: ;
    endcase
    reset             = in_reset;
    bus.n64_request   = n64_req;
    bus.n64_write     = n64_wr;
    bus.n64_address   = n64_addr;
    bus.n64_wdata     = n64_wd;
    bus.cpu_request   = cpu_req;
    bus.cpu_write     = cpu_wr;
    bus.cpu_address   = cpu_addr;
    bus.cpu_wdata     = cpu_wd;
    bus.mem_ack       = mem_ack_v;
    bus.mem_rdata     = mem_rd;
    bus.timeout_clear = tclr;
    #1;
    timed_out = (owner != 0) && !mem_ack_v && (waitc == int'(TIMEOUT));
    done      = (owner != 0) && !in_reset && (mem_ack_v || timed_out);
    exp_rd    = mem_ack_v ? mem_rd : 16'hFFFF;

    check("n64_ack", 32'(bus.n64_ack), 32'(done && owner == 1));
    check("cpu_ack", 32'(bus.cpu_ack), 32'(done && owner == 2));
    if (done && owner == 1) check("n64_rdata", 32'(bus.n64_rdata), 32'(exp_rd));
    if (done && owner == 2) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
    check("mem_request",   32'(bus.mem_request),   32'(m_req));
    check("mem_write",     32'(bus.mem_write),     32'(m_wr));
    check("mem_address",   bus.mem_address,        m_addr);
    check("mem_wdata",     32'(bus.mem_wdata),     32'(m_wdata));
    check("timeout_error", 32'(bus.timeout_error), 32'(err));

    saw_n64_ack = bus.n64_ack;
    saw_cpu_ack = bus.cpu_ack;
    n64_ack_cnt += int'(bus.n64_ack);
    cpu_ack_cnt += int'(bus.cpu_ack);

    // advance the model to the state after the coming rising edge
    if (in_reset) begin
      owner = 0; burst = 0; waitc = 0; err = 1'b0;
      m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    end else begin
      if (timed_out) err = 1'b1;
      else if (tclr) err = 1'b0;
      if (owner == 0) begin
        if (n64_req && !(cpu_req && burst == int'(BURST_MAX))) begin
          owner = 1; m_req = 1'b1; waitc = 0;
          m_wr = n64_wr; m_addr = n64_addr; m_wdata = n64_wd;
          if (!cpu_req) burst = 0;
          else if (burst < int'(BURST_MAX)) burst++;
        end else if (cpu_req) begin
          owner = 2; m_req = 1'b1; waitc = 0; burst = 0;
          m_wr = cpu_wr; m_addr = cpu_addr; m_wdata = cpu_wd;
        end
      end else if (mem_ack_v || timed_out) begin
        owner = 0; m_req = 1'b0;
      end else begin
        waitc++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, grants, n64_before, cpu_before;
    n_checks = 0; n_pass = 0; lat = -1; resp_mode = 0;
    owner = 0; burst = 0; waitc = 0; err = 1'b0;
    m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    n64_req = 0; n64_wr = 0; n64_addr = '0; n64_wd = '0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wd = '0;
    mem_ack_v = 0; mem_rd = '0; tclr = 0;

    // reset state
    in_reset = 1'b1;
    repeat (3) cycle();
    in_reset = 1'b0;
    cycle();
    check("rst_mem_request", 32'(bus.mem_request), 32'd0);
    check("rst_timeout_error", 32'(bus.timeout_error), 32'd0);

    // single N64 read, ack on the third grant cycle
    n64_ack_cnt = 0; cpu_ack_cnt = 0;
    n64_req = 1; n64_wr = 0; n64_addr = 32'h1000_0000;
    cycle();
    check("rd_mreq_same_cycle", 32'(bus.mem_request), 32'd0);
    cycle();
    check("rd_mreq_latency", 32'(bus.mem_request), 32'd1);
    check("rd_maddr", bus.mem_address, 32'h1000_0000);
    cycle();
    mem_ack_v = 1; mem_rd = 16'hBEEF;
    cycle();
    check("rd_ack", 32'(saw_n64_ack), 32'd1);
    check("rd_rdata", 32'(bus.n64_rdata), 32'h0000_BEEF);
    n64_req = 0; mem_ack_v = 0;
    repeat (2) cycle();
    check("rd_ack_pulses", 32'(n64_ack_cnt), 32'd1);
    check("rd_cpu_ack_none", 32'(cpu_ack_cnt), 32'd0);

    // both ports requesting continuously, immediate ack
    n64_req = 1; n64_addr = 32'h1000_0040; n64_wr = 0;
    cpu_req = 1; cpu_addr = 32'h0000_0200; cpu_wr = 0;
    resp_mode = 2; grants = 0;
    for (int c = 0; c < 80 && grants < 18; c++) begin
      cycle();
      if (saw_n64_ack || saw_cpu_ack) begin
        check($sformatf("fair_grant%0d", grants), 32'(saw_cpu_ack), 32'(grants % 9 == 8));
        grants++;
      end
    end
    check("fair_grant_count", 32'(grants), 32'd18);
    n64_req = 0; cpu_req = 0; resp_mode = 0; mem_ack_v = 0;
    cycle();

    // CPU write with the N64 idle
    cpu_ack_cnt = 0;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h0000_0100; cpu_wd = 16'h1234;
    cycle();
    cycle();
    check("wr_mem_write", 32'(bus.mem_write), 32'd1);
    check("wr_mem_wdata", 32'(bus.mem_wdata), 32'h0000_1234);
    check("wr_mem_address", bus.mem_address, 32'h0000_0100);
    mem_ack_v = 1; mem_rd = 16'h0F0F;
    cycle();
    check("wr_cpu_ack", 32'(saw_cpu_ack), 32'd1);
    cpu_req = 0; cpu_wr = 0; mem_ack_v = 0;
    cycle();
    check("wr_cpu_ack_pulses", 32'(cpu_ack_cnt), 32'd1);
    check("wr_burst_count", 32'(dut.burst_count), 32'd0);

    // timeout with mem_ack withheld; clear held high the whole time loses to set
    n64_req = 1; n64_wr = 0; n64_addr = 32'h1234_5678; tclr = 1;
    cycle();
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (saw_n64_ack) break;
      cnt++;
    end
    check("to_wait_cycles", 32'(cnt), 32'(TIMEOUT));
    check("to_rdata", 32'(bus.n64_rdata), 32'h0000_FFFF);
    n64_req = 0; tclr = 0;
    cycle();
    check("to_error_set", 32'(bus.timeout_error), 32'd1);
    tclr = 1;
    cycle();
    tclr = 0;
    cycle();
    check("to_error_cleared", 32'(bus.timeout_error), 32'd0);

    // mem_ack in the limit cycle wins over the abort
    n64_req = 1; n64_addr = 32'h2000_0000;
    cycle();
    repeat (TIMEOUT) cycle();
    mem_ack_v = 1; mem_rd = 16'h5A5A;
    cycle();
    check("tie_ack", 32'(saw_n64_ack), 32'd1);
    check("tie_rdata", 32'(bus.n64_rdata), 32'h0000_5A5A);
    n64_req = 0; mem_ack_v = 0;
    cycle();
    check("tie_no_error", 32'(bus.timeout_error), 32'd0);

    // reset two cycles into a CPU transaction, late mem_ack afterwards
    cpu_ack_cnt = 0;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h0000_0300; cpu_wd = 16'hCAFE;
    cycle();
    cycle();
    in_reset = 1;
    cycle();
    in_reset = 0; cpu_req = 0; cpu_wr = 0; mem_ack_v = 1; mem_rd = 16'h1111;
    cycle();
    check("rst_mid_no_ack", 32'(cpu_ack_cnt), 32'd0);
    check("rst_mid_mem_request", 32'(bus.mem_request), 32'd0);
    check("rst_mid_mem_address", bus.mem_address, 32'd0);
    check("rst_mid_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_mid_mem_write", 32'(bus.mem_write), 32'd0);
    mem_ack_v = 0;
    cycle();

    // randomized traffic
    resp_mode = 1;
    for (int c = 0; c < 6000; c++) begin
      in_reset = ($urandom_range(0, 299) == 0);
      tclr     = ($urandom_range(0, 15) == 0);
      n64_before = int'(n64_req);
      if (n64_req && saw_n64_ack) n64_req = ($urandom_range(0, 2) != 0);
      else if (!n64_req)          n64_req = ($urandom_range(0, 3) == 0);
      if (n64_req && (saw_n64_ack || n64_before == 0)) begin
        n64_wr = 1'($urandom_range(0, 1)); n64_addr = $urandom; n64_wd = 16'($urandom);
      end
      cpu_before = int'(cpu_req);
      if (cpu_req && saw_cpu_ack) cpu_req = ($urandom_range(0, 2) != 0);
      else if (!cpu_req)          cpu_req = ($urandom_range(0, 3) == 0);
      if (cpu_req && (saw_cpu_ack || cpu_before == 0)) begin
        cpu_wr = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wd = 16'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
